stage_4: RTL and testbench
==========================

Name: stage_4

Overview:
Memory (MEM) stage of the 5-stage MIPS pipeline. It owns the data memory and resolves branch/jump/call/return redirects into a 12-bit next_PC. It registers ALU result, load data and write-back control into the MEM/WB pipeline register. It sits between the EX stage (Stage3) and the WB stage.

Parameters:
DMEM_DEPTH, 4096, data memory words, 32-bit each; address = low log2(DMEM_DEPTH) bits of the word address.
DATA_W, 32, datapath width.
PC_W, 12, program counter / stack pointer width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-low reset
BR_Ex  in  1  branch taken (resolved in EX)
JMP_flag  in  1  unconditional jump
imm  in  16  jump/branch target; low 12 bits used
CALL_flag  in  1  call: push return address, jump to imm
RET_flag  in  1  return: pop target from stack
Memory_Read  in  1  load enable
Memory_Write  in  1  store enable
Result  in  32  ALU result / load-store address
SP_Data  in  12  current stack pointer (stack slot address)
data1  in  32  store data; on CALL, return address in data1[11:0]
Addr_Write_Reg_in  in  5  destination register
Reg_Write_En_in  in  1  register write enable
WB_Mux_sel_in  in  1  WB select (1 = memory, 0 = ALU)
BR_JMP_Ex  out  1  PC redirect request
next_PC  out  12  redirect target
Mem_out_no_Pipeline  out  32  combinational load data
ALU_out_no_Pipeline  out  32  combinational copy of Result
Result_out  out  32  registered Result
Addr_Write_Reg_out  out  5  registered destination
Memory_Data  out  32  registered load data
Reg_Write_En_out  out  1  registered write enable
WB_Mux_sel_out  out  1  registered WB select

Behaviour:
- Single clock domain; reset synchronous, active-low, sampled on rising clk edge.
- Redirect (combinational): BR_JMP_Ex = BR_Ex | JMP_flag | CALL_flag | RET_flag.
- next_PC = RET_flag ? mem[SP_Data][11:0] : imm[11:0]. RET has priority over CALL, JMP and BR. next_PC is driven even when BR_JMP_Ex = 0.
- Load: Mem_out_no_Pipeline = mem[Result] (asynchronous read) when Memory_Read = 1, else 0.
- ALU_out_no_Pipeline = Result (combinational).
- Writes on rising edge only. Memory writes are not blocked by reset.
  - CALL_flag = 1: mem[SP_Data] <= {20'b0, data1[11:0]}.
  - Else if Memory_Write = 1: mem[Result] <= data1.
  - CALL wins if both are asserted; no write otherwise.
- The stack pointer is not modified here; SP update belongs to the ID stage.
- Pipeline register, 1-cycle latency, on rising edge: Result_out <= Result, Memory_Data <= Mem_out_no_Pipeline, Addr_Write_Reg_out, Reg_Write_En_out and WB_Mux_sel_out <= their inputs.
- Reset (reset = 0): all registered outputs set to 0. Memory contents are not cleared; they are undefined until written.
- Addresses wider than the memory wrap (upper bits ignored).
- No handshake; the block accepts one instruction per cycle.

Optional Feature:
Macro STAGE4_DMEM_RDW_FWD_EN.
- Defined: when Memory_Read and Memory_Write are both 1 on the same address in the same cycle, Mem_out_no_Pipeline = data1 (write-first forwarding).
- Undefined: Mem_out_no_Pipeline returns the pre-write memory contents.

Decomposition:
- Package stage4_pkg: DATA_W = 32, PC_W = 12, REG_ADDR_W = 5, IMM_W = 16, DMEM_DEPTH default.
- One sub-module stage4_dmem: dual-address RAM.
  - Asynchronous read ports: data port at Result, stack port at SP_Data.
  - One synchronous write port with CALL/store mux selection.
- Redirect logic and the pipeline register stay in the top level.

Test Plan:
- Hold reset = 0 for one edge with all inputs nonzero -> Result_out = 0, Memory_Data = 0, Addr_Write_Reg_out = 0, Reg_Write_En_out = 0, WB_Mux_sel_out = 0.
- reset = 1, all flags 0, imm = 9 -> BR_JMP_Ex = 0, next_PC = 9. Then BR_Ex = 1 -> BR_JMP_Ex = 1, next_PC = 9. Then BR_Ex = 0, JMP_flag = 1 -> BR_JMP_Ex = 1, next_PC = 9. Then JMP_flag = 0 -> BR_JMP_Ex = 0.
- Store then load:
  - Store: Memory_Write = 1, Result = 5, data1 = 0xDEADBEEF.
  - Next cycle load: Memory_Read = 1, Result = 5 -> Mem_out_no_Pipeline = 0xDEADBEEF immediately; Memory_Data = 0xDEADBEEF one edge later.
- CALL then RET:
  - CALL: CALL_flag = 1, SP_Data = 0xFFF, data1 = 0x023, imm = 0x040 -> BR_JMP_Ex = 1, next_PC = 0x040.
  - Later RET: RET_flag = 1, SP_Data = 0xFFF -> next_PC = 0x023, BR_JMP_Ex = 1.
- Pass-through: Result = 0x12345678, Addr_Write_Reg_in = 7, Reg_Write_En_in = 1, WB_Mux_sel_in = 0 -> ALU_out_no_Pipeline = 0x12345678 immediately; registered outputs match after one edge.
- Simultaneous events:
  - Memory_Read = Memory_Write = 1 at address 3 with data1 = 0xAA -> Mem_out_no_Pipeline = 0xAA with STAGE4_DMEM_RDW_FWD_EN, old value without.
  - RET_flag = 1 and JMP_flag = 1 together -> next_PC taken from the stack.

Source files
------------

// File: rtl/stage4_pkg.sv
// Shared widths, memory geometry and the MEM/WB pipeline record for the MEM stage.
package stage4_pkg;

  localparam int DATA_W     = 32;
  localparam int PC_W       = 12;
  localparam int REG_ADDR_W = 5;
  localparam int IMM_W      = 16;
  localparam int DMEM_DEPTH = 4096;
  localparam int DMEM_AW    = $clog2(DMEM_DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic [DATA_W-1:0]     mem_data;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_we;
    logic                  wb_sel;
  } mem_wb_t;

endpackage

// File: rtl/stage4_dmem.sv
// Data memory: two asynchronous read ports (data and stack) and one synchronous
// write port where a CALL return-address push takes precedence over a store.
module stage4_dmem
  import stage4_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [AW-1:0]     data_addr,
  input  logic [AW-1:0]     stack_addr,
  input  logic              call_en,
  input  logic              store_en,
  input  logic [PC_W-1:0]   ret_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] data_word,
  output logic [PC_W-1:0]   stack_word
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch so it maps onto RAM; contents stay undefined until written.
  always_ff @(posedge clk) begin
    if (call_en) begin
      mem[stack_addr] <= {{(DATA_W-PC_W){1'b0}}, ret_addr};
    end else if (store_en) begin
      mem[data_addr] <= store_data;
    end
  end

  assign data_word  = mem[data_addr];
  assign stack_word = mem[stack_addr][PC_W-1:0];

endmodule

// File: rtl/stage_4.sv
// MIPS MEM stage: data memory, branch/jump/call/return redirect and MEM/WB register.
// Define STAGE4_DMEM_RDW_FWD_EN to return store data on a same-cycle load/store.
module stage_4
  import stage4_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  BR_Ex,
  input  logic                  JMP_flag,
  input  logic [IMM_W-1:0]      imm,
  input  logic                  CALL_flag,
  input  logic                  RET_flag,
  input  logic                  Memory_Read,
  input  logic                  Memory_Write,
  input  logic [DATA_W-1:0]     Result,
  input  logic [PC_W-1:0]       SP_Data,
  input  logic [DATA_W-1:0]     data1,
  input  logic [REG_ADDR_W-1:0] Addr_Write_Reg_in,
  input  logic                  Reg_Write_En_in,
  input  logic                  WB_Mux_sel_in,
  output logic                  BR_JMP_Ex,
  output logic [PC_W-1:0]       next_PC,
  output logic [DATA_W-1:0]     Mem_out_no_Pipeline,
  output logic [DATA_W-1:0]     ALU_out_no_Pipeline,
  output logic [DATA_W-1:0]     Result_out,
  output logic [REG_ADDR_W-1:0] Addr_Write_Reg_out,
  output logic [DATA_W-1:0]     Memory_Data,
  output logic                  Reg_Write_En_out,
  output logic                  WB_Mux_sel_out
);

  logic [DMEM_AW-1:0] data_addr;
  logic [DMEM_AW-1:0] stack_addr;
  logic [DATA_W-1:0]  data_word;
  logic [PC_W-1:0]    stack_word;
  logic [IMM_W-PC_W-1:0] unused_imm_hi;
  mem_wb_t            wb_q;

  // Upper address bits are ignored so oversized addresses wrap around the memory.
  assign data_addr     = Result[DMEM_AW-1:0];
  assign stack_addr    = DMEM_AW'(SP_Data);
  assign unused_imm_hi = imm[IMM_W-1:PC_W];

  stage4_dmem #(
    .DEPTH(DMEM_DEPTH)
  ) u_dmem (
    .clk       (clk),
    .data_addr (data_addr),
    .stack_addr(stack_addr),
    .call_en   (CALL_flag),
    .store_en  (Memory_Write),
    .ret_addr  (data1[PC_W-1:0]),
    .store_data(data1),
    .data_word (data_word),
    .stack_word(stack_word)
  );

  assign BR_JMP_Ex           = BR_Ex | JMP_flag | CALL_flag | RET_flag;
  assign next_PC             = RET_flag ? stack_word : imm[PC_W-1:0];
  assign ALU_out_no_Pipeline = Result;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    Mem_out_no_Pipeline = '0;
    if (Memory_Read) begin
`ifdef STAGE4_DMEM_RDW_FWD_EN
      Mem_out_no_Pipeline = Memory_Write ? data1 : data_word;
`else
      Mem_out_no_Pipeline = data_word;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_q <= '0;
    end else begin
      wb_q.result   <= Result;
      wb_q.mem_data <= Mem_out_no_Pipeline;
      wb_q.rd_addr  <= Addr_Write_Reg_in;
      wb_q.reg_we   <= Reg_Write_En_in;
      wb_q.wb_sel   <= WB_Mux_sel_in;
    end
  end

  assign Result_out         = wb_q.result;
  assign Memory_Data        = wb_q.mem_data;
  assign Addr_Write_Reg_out = wb_q.rd_addr;
  assign Reg_Write_En_out   = wb_q.reg_we;
  assign WB_Mux_sel_out     = wb_q.wb_sel;

endmodule

// File: tb/tb_stage_4.sv
// Self-checking bench for stage_4: directed plan steps, then randomized traffic
// compared against an associative-array model of memory and the stage rules.
module tb_stage_4;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        BR_Ex, JMP_flag, CALL_flag, RET_flag;
  logic [15:0] imm;
  logic        Memory_Read, Memory_Write;
  logic [31:0] Result;
  logic [11:0] SP_Data;
  logic [31:0] data1;
  logic [4:0]  Addr_Write_Reg_in;
  logic        Reg_Write_En_in, WB_Mux_sel_in;
  logic        BR_JMP_Ex;
  logic [11:0] next_PC;
  logic [31:0] Mem_out_no_Pipeline, ALU_out_no_Pipeline, Result_out, Memory_Data;
  logic [4:0]  Addr_Write_Reg_out;
  logic        Reg_Write_En_out, WB_Mux_sel_out;

  int passed = 0;
  int total  = 0;
  logic [31:0] model_mem [int];

  always #5 clk = ~clk;

  stage_4 dut (
    .clk(clk), .reset(reset), .BR_Ex(BR_Ex), .JMP_flag(JMP_flag), .imm(imm),
    .CALL_flag(CALL_flag), .RET_flag(RET_flag), .Memory_Read(Memory_Read),
    .Memory_Write(Memory_Write), .Result(Result), .SP_Data(SP_Data), .data1(data1),
    .Addr_Write_Reg_in(Addr_Write_Reg_in), .Reg_Write_En_in(Reg_Write_En_in),
    .WB_Mux_sel_in(WB_Mux_sel_in), .BR_JMP_Ex(BR_JMP_Ex), .next_PC(next_PC),
    .Mem_out_no_Pipeline(Mem_out_no_Pipeline), .ALU_out_no_Pipeline(ALU_out_no_Pipeline),
    .Result_out(Result_out), .Addr_Write_Reg_out(Addr_Write_Reg_out),
    .Memory_Data(Memory_Data), .Reg_Write_En_out(Reg_Write_En_out),
    .WB_Mux_sel_out(WB_Mux_sel_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    BR_Ex = 0; JMP_flag = 0; CALL_flag = 0; RET_flag = 0; imm = '0;
    Memory_Read = 0; Memory_Write = 0; Result = '0; SP_Data = '0; data1 = '0;
    Addr_Write_Reg_in = '0; Reg_Write_En_in = 0; WB_Mux_sel_in = 0;
  endtask

  // One instruction: check combinational outputs, clock it, check the MEM/WB register.
  task automatic run_cycle(input string tag);
    int          a, s;
    logic [31:0] exp_ld;
    logic        ld_known;
    a = int'(Result % DEPTH);
    s = int'(SP_Data);
    #1;
    check({tag, ".br_jmp"}, 32'(BR_JMP_Ex), 32'(BR_Ex | JMP_flag | CALL_flag | RET_flag));
    if (!RET_flag) check({tag, ".next_pc"}, 32'(next_PC), 32'(imm % 4096));
    else if (model_mem.exists(s)) check({tag, ".next_pc_ret"}, 32'(next_PC), model_mem[s] % 4096);
    ld_known = 1'b1;
    exp_ld   = '0;
    if (Memory_Read) begin
`ifdef STAGE4_DMEM_RDW_FWD_EN
      if (Memory_Write) exp_ld = data1;
      else if (model_mem.exists(a)) exp_ld = model_mem[a];
      else ld_known = 1'b0;
`else
      if (model_mem.exists(a)) exp_ld = model_mem[a];
      else ld_known = 1'b0;
`endif
    end
    if (ld_known) check({tag, ".mem_out"}, Mem_out_no_Pipeline, exp_ld);
    check({tag, ".alu_out"}, ALU_out_no_Pipeline, Result);
    @(posedge clk);
    #1;
    if (!reset) begin
      check({tag, ".rst_result"}, Result_out, 32'h0);
      check({tag, ".rst_memdata"}, Memory_Data, 32'h0);
      check({tag, ".rst_rd"}, 32'(Addr_Write_Reg_out), 32'h0);
      check({tag, ".rst_we"}, 32'(Reg_Write_En_out), 32'h0);
      check({tag, ".rst_wbsel"}, 32'(WB_Mux_sel_out), 32'h0);
    end else begin
      check({tag, ".result_q"}, Result_out, Result);
      if (ld_known) check({tag, ".memdata_q"}, Memory_Data, exp_ld);
      check({tag, ".rd_q"}, 32'(Addr_Write_Reg_out), 32'(Addr_Write_Reg_in));
      check({tag, ".we_q"}, 32'(Reg_Write_En_out), 32'(Reg_Write_En_in));
      check({tag, ".wbsel_q"}, 32'(WB_Mux_sel_out), 32'(WB_Mux_sel_in));
    end
    if (CALL_flag) model_mem[s] = data1 % 4096;
    else if (Memory_Write) model_mem[a] = data1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;

    // Reset with every input active: registered outputs must clear, memory still writes.
    BR_Ex = 1; JMP_flag = 1; CALL_flag = 1; RET_flag = 1; imm = 16'h1234;
    Memory_Read = 1; Memory_Write = 1; Result = 32'h0000_0005; SP_Data = 12'h800;
    data1 = 32'h5555_0321; Addr_Write_Reg_in = 5'h1f; Reg_Write_En_in = 1; WB_Mux_sel_in = 1;
    run_cycle("reset");

    reset = 1'b1;
    clear_inputs();
    imm = 16'd9;
    run_cycle("idle_imm9");
    BR_Ex = 1;
    run_cycle("branch");
    BR_Ex = 0; JMP_flag = 1;
    run_cycle("jump");
    JMP_flag = 0;
    run_cycle("no_redirect");

    Memory_Write = 1; Result = 32'd5; data1 = 32'hDEAD_BEEF;
    run_cycle("store5");
    Memory_Write = 0; Memory_Read = 1;
    run_cycle("load5");
    check("load5_const", Memory_Data, 32'hDEAD_BEEF);
    Memory_Read = 0;

    CALL_flag = 1; SP_Data = 12'hFFF; data1 = 32'h0000_0023; imm = 16'h0040;
    run_cycle("call");
    CALL_flag = 0;
    run_cycle("after_call");
    RET_flag = 1;
    run_cycle("ret");
    check("ret_pc_const", 32'(next_PC), 32'h023);
    RET_flag = 0;

    Result = 32'h1234_5678; Addr_Write_Reg_in = 5'd7; Reg_Write_En_in = 1; WB_Mux_sel_in = 0;
    run_cycle("passthru");

    Memory_Write = 1; Result = 32'd3; data1 = 32'h11;
    run_cycle("store3");
    Memory_Read = 1; data1 = 32'hAA;
    run_cycle("rdw3");
    Memory_Write = 0;
    run_cycle("load3_after");
    check("load3_after_const", Mem_out_no_Pipeline, 32'hAA);
    Memory_Read = 0;

    RET_flag = 1; JMP_flag = 1; SP_Data = 12'hFFF; imm = 16'h0100;
    run_cycle("ret_jmp");
    check("ret_jmp_const", 32'(next_PC), 32'h023);
    clear_inputs();

    // Upper address bits wrap: 0xABCDE005 aliases word 5.
    Memory_Write = 1; Result = 32'hABCD_E005; data1 = 32'h0000_0077;
    run_cycle("wrap_store");
    Memory_Write = 0; Memory_Read = 1; Result = 32'd5;
    run_cycle("wrap_load");
    check("wrap_load_const", Mem_out_no_Pipeline, 32'h77);
    clear_inputs();

    // Fill small data and stack pools so every random access has a known model value.
    for (int i = 0; i < 16; i++) begin
      clear_inputs();
      Memory_Write = 1; Result = 32'(i); data1 = $urandom;
      run_cycle("fill_data");
      clear_inputs();
      CALL_flag = 1; SP_Data = 12'hFF0 | 12'(i); data1 = $urandom;
      run_cycle("fill_stack");
    end

    for (int n = 0; n < 300; n++) begin
      reset             = ($urandom_range(0, 24) != 0);
      BR_Ex             = ($urandom_range(0, 3) == 0);
      JMP_flag          = ($urandom_range(0, 3) == 0);
      CALL_flag         = ($urandom_range(0, 3) == 0);
      RET_flag          = ($urandom_range(0, 3) == 0);
      Memory_Read       = $urandom_range(0, 1) == 1;
      Memory_Write      = $urandom_range(0, 1) == 1;
      imm               = 16'($urandom);
      Result            = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15));
      SP_Data           = 12'hFF0 | 12'($urandom_range(0, 15));
      data1             = $urandom;
      Addr_Write_Reg_in = 5'($urandom);
      Reg_Write_En_in   = $urandom_range(0, 1) == 1;
      WB_Mux_sel_in     = $urandom_range(0, 1) == 1;
      run_cycle("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
